// File: rtl/ekf_stage_sequencer_pkg.sv
// rtl/ekf_stage_sequencer_pkg.sv - stage codes, data format and state type for the EKF stage sequencer
package ekf_stage_sequencer_pkg;

    // Command codes understood by the EKF-SLAM core on stage_val
    localparam logic [2:0] STAGE_IDLE  = 3'b000;
    localparam logic [2:0] STAGE_PRD   = 3'b001;
    localparam logic [2:0] STAGE_NEW   = 3'b010;
    localparam logic [2:0] STAGE_UPD   = 3'b011;
    localparam logic [2:0] STAGE_ASSOC = 3'b100;

    // Operand format: sign + integer bits + fraction bits
    localparam int DATA_INT_BIT = 12;
    localparam int DATA_DEC_BIT = 19;
    localparam int DATA_W       = 1 + DATA_INT_BIT + DATA_DEC_BIT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OBS_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT
    } seq_state_e;

endpackage

// File: rtl/ekf_stage_sequencer.sv
// rtl/ekf_stage_sequencer.sv - orders PRD/NEW/ASSOC/UPD commands to the EKF core from odometry and scans
module ekf_stage_sequencer
    import ekf_stage_sequencer_pkg::*;
#(
    parameter int RSA_DW       = DATA_W,
    parameter int ROW_LEN      = 10,
    parameter int PRD_PER_SCAN = 10,
    parameter int STAGE_HOLD   = 2,
    parameter int MAX_LM       = 1023
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              seq_en,
    input  logic              odo_valid,
    output logic              odo_ready,
    input  logic [RSA_DW-1:0] odo_vlr,
    input  logic [RSA_DW-1:0] odo_alpha,
    input  logic              obs_valid,
    output logic              obs_ready,
    input  logic [RSA_DW-1:0] obs_rk,
    input  logic [RSA_DW-1:0] obs_phi,
    input  logic              obs_last,
    output logic [2:0]        stage_val,
    output logic [RSA_DW-1:0] vlr,
    output logic [RSA_DW-1:0] alpha,
    output logic [RSA_DW-1:0] rk,
    output logic [RSA_DW-1:0] phi,
    input  logic              stage_rdy,
    input  logic              assoc_new,
    output logic [ROW_LEN-1:0] landmark_num,
    output logic              busy,
    output logic              err
);

    localparam int PW = $clog2(PRD_PER_SCAN + 1);
    localparam int HW = $clog2(STAGE_HOLD + 1);
    localparam logic [PW-1:0]      PRD_LIM  = PW'(PRD_PER_SCAN);
    localparam logic [HW-1:0]      HOLD_LIM = HW'(STAGE_HOLD);
    localparam logic [ROW_LEN-1:0] LM_LIM   = ROW_LEN'(MAX_LM);

    seq_state_e         state_q, state_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [2:0]         stage_val_q, stage_val_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [PW-1:0]      prd_cnt_q, prd_cnt_d;
    logic               first_scan_q, first_scan_d;
    logic               last_q, last_d;
    logic [ROW_LEN-1:0] lm_q, lm_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               odo_ready_q, odo_ready_d;
    logic               obs_ready_q, obs_ready_d;
    logic [RSA_DW-1:0]  vlr_q, vlr_d, alpha_q, alpha_d, rk_q, rk_d, phi_q, phi_d;

    logic odo_hs;
    logic obs_hs;

    assign odo_hs = odo_valid && odo_ready_q;
    assign obs_hs = obs_valid && obs_ready_q;

    // Next-state, command and counter logic; a NEW that would overflow the landmark table is dropped
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        stage_val_d  = stage_val_q;
        hold_cnt_d   = hold_cnt_q;
        prd_cnt_d    = prd_cnt_q;
        first_scan_d = first_scan_q;
        last_d       = last_q;
        lm_d         = lm_q;
        err_d        = err_q;
        vlr_d        = vlr_q;
        alpha_d      = alpha_q;
        rk_d         = rk_q;
        phi_d        = phi_q;

        case (state_q)
            ST_IDLE: begin
                stage_val_d = STAGE_IDLE;
                if (stage_rdy) err_d = 1'b1;
                if (odo_hs) begin
                    vlr_d       = odo_vlr;
                    alpha_d     = odo_alpha;
                    cmd_d       = STAGE_PRD;
                    stage_val_d = STAGE_PRD;
                    hold_cnt_d  = HW'(1);
                    state_d     = ST_ISSUE;
                end else if (seq_en && (prd_cnt_q >= PRD_LIM)) begin
                    state_d = ST_OBS_FETCH;
                end
            end
            ST_OBS_FETCH: begin
                stage_val_d = STAGE_IDLE;
                if (stage_rdy) err_d = 1'b1;
                if (obs_hs) begin
                    rk_d   = obs_rk;
                    phi_d  = obs_phi;
                    last_d = obs_last;
                    if (first_scan_q && (lm_q == LM_LIM)) begin
                        err_d   = 1'b1;
                        state_d = ST_NEXT;
                    end else begin
                        cmd_d       = first_scan_q ? STAGE_NEW : STAGE_ASSOC;
                        stage_val_d = first_scan_q ? STAGE_NEW : STAGE_ASSOC;
                        hold_cnt_d  = HW'(1);
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (stage_rdy) err_d = 1'b1;
                // Entered with hold_cnt=0 after an ASSOC, which inserts one quiet cycle before re-issue
                if (hold_cnt_q < HOLD_LIM) begin
                    stage_val_d = cmd_q;
                    hold_cnt_d  = hold_cnt_q + HW'(1);
                end else begin
                    stage_val_d = STAGE_IDLE;
                    hold_cnt_d  = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stage_val_d = STAGE_IDLE;
                if (stage_rdy) begin
                    case (cmd_q)
                        STAGE_PRD: begin
                            prd_cnt_d = prd_cnt_q + PW'(1);
                            state_d   = ST_IDLE;
                        end
                        STAGE_NEW: begin
                            lm_d    = lm_q + ROW_LEN'(1);
                            state_d = ST_NEXT;
                        end
                        STAGE_ASSOC: begin
                            hold_cnt_d = '0;
                            if (!assoc_new) begin
                                cmd_d   = STAGE_UPD;
                                state_d = ST_ISSUE;
                            end else if (lm_q == LM_LIM) begin
                                err_d   = 1'b1;
                                state_d = ST_NEXT;
                            end else begin
                                cmd_d   = STAGE_NEW;
                                state_d = ST_ISSUE;
                            end
                        end
                        default: state_d = ST_NEXT;
                    endcase
                end
            end
            ST_NEXT: begin
                stage_val_d = STAGE_IDLE;
                if (last_q) begin
                    prd_cnt_d    = '0;
                    first_scan_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_OBS_FETCH;
                end
            end
            default: begin
                stage_val_d = STAGE_IDLE;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Ready and busy are decided from the upcoming state so they are registered and mutually exclusive
    always_comb begin
        odo_ready_d = (state_d == ST_IDLE) && seq_en && (prd_cnt_d < PRD_LIM);
        obs_ready_d = (state_d == ST_OBS_FETCH);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any command in flight
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            cmd_q        <= STAGE_IDLE;
            stage_val_q  <= STAGE_IDLE;
            hold_cnt_q   <= '0;
            prd_cnt_q    <= '0;
            first_scan_q <= 1'b1;
            last_q       <= 1'b0;
            lm_q         <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            odo_ready_q  <= 1'b0;
            obs_ready_q  <= 1'b0;
            vlr_q        <= '0;
            alpha_q      <= '0;
            rk_q         <= '0;
            phi_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            stage_val_q  <= stage_val_d;
            hold_cnt_q   <= hold_cnt_d;
            prd_cnt_q    <= prd_cnt_d;
            first_scan_q <= first_scan_d;
            last_q       <= last_d;
            lm_q         <= lm_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            odo_ready_q  <= odo_ready_d;
            obs_ready_q  <= obs_ready_d;
            vlr_q        <= vlr_d;
            alpha_q      <= alpha_d;
            rk_q         <= rk_d;
            phi_q        <= phi_d;
        end
    end

    assign odo_ready    = odo_ready_q;
    assign obs_ready    = obs_ready_q;
    assign stage_val    = stage_val_q;
    assign vlr          = vlr_q;
    assign alpha        = alpha_q;
    assign rk           = rk_q;
    assign phi          = phi_q;
    assign landmark_num = lm_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_ekf_stage_sequencer.sv
// tb/tb_ekf_stage_sequencer.sv - self-checking bench for ekf_stage_sequencer
module tb_ekf_stage_sequencer;

    localparam logic [2:0] C_PRD   = 3'd1;
    localparam logic [2:0] C_NEW   = 3'd2;
    localparam logic [2:0] C_UPD   = 3'd3;
    localparam logic [2:0] C_ASSOC = 3'd4;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        seq_en_a = 1'b0, seq_en_b = 1'b0;
    logic        odo_valid = 1'b0, obs_valid = 1'b0, obs_last = 1'b0;
    logic [31:0] odo_vlr = '0, odo_alpha = '0, obs_rk = '0, obs_phi = '0;
    logic        stage_rdy = 1'b0, assoc_new = 1'b0;

    logic        a_odo_ready, a_obs_ready, a_busy, a_err;
    logic        b_odo_ready, b_obs_ready, b_busy, b_err;
    logic [2:0]  a_stage_val, b_stage_val;
    logic [31:0] a_vlr, a_alpha, a_rk, a_phi, b_vlr, b_alpha, b_rk, b_phi;
    logic [9:0]  a_lm, b_lm;

    logic        odo_ready, obs_ready, busy, err;
    logic [2:0]  stage_val;
    logic [31:0] vlr, alpha, rk, phi;
    logic [9:0]  landmark_num;

    int total = 0;
    int bad = 0;
    int m_lm, m_err, m_first, cur_prd, cur_max;
    bit spur_next = 0;
    bit plan_q[$];

    always #5 clk = ~clk;

    ekf_stage_sequencer u_main (
        .clk(clk), .sys_rst_n(sys_rst_n), .seq_en(seq_en_a),
        .odo_valid(odo_valid & ~sel), .odo_ready(a_odo_ready), .odo_vlr(odo_vlr), .odo_alpha(odo_alpha),
        .obs_valid(obs_valid & ~sel), .obs_ready(a_obs_ready), .obs_rk(obs_rk), .obs_phi(obs_phi),
        .obs_last(obs_last), .stage_val(a_stage_val), .vlr(a_vlr), .alpha(a_alpha), .rk(a_rk), .phi(a_phi),
        .stage_rdy(stage_rdy & ~sel), .assoc_new(assoc_new), .landmark_num(a_lm), .busy(a_busy), .err(a_err)
    );

    ekf_stage_sequencer #(.PRD_PER_SCAN(2), .MAX_LM(2)) u_small (
        .clk(clk), .sys_rst_n(sys_rst_n), .seq_en(seq_en_b),
        .odo_valid(odo_valid & sel), .odo_ready(b_odo_ready), .odo_vlr(odo_vlr), .odo_alpha(odo_alpha),
        .obs_valid(obs_valid & sel), .obs_ready(b_obs_ready), .obs_rk(obs_rk), .obs_phi(obs_phi),
        .obs_last(obs_last), .stage_val(b_stage_val), .vlr(b_vlr), .alpha(b_alpha), .rk(b_rk), .phi(b_phi),
        .stage_rdy(stage_rdy & sel), .assoc_new(assoc_new), .landmark_num(b_lm), .busy(b_busy), .err(b_err)
    );

    always_comb begin
        if (sel) begin
            odo_ready = b_odo_ready; obs_ready = b_obs_ready; stage_val = b_stage_val;
            vlr = b_vlr; alpha = b_alpha; rk = b_rk; phi = b_phi;
            landmark_num = b_lm; busy = b_busy; err = b_err;
        end else begin
            odo_ready = a_odo_ready; obs_ready = a_obs_ready; stage_val = a_stage_val;
            vlr = a_vlr; alpha = a_alpha; rk = a_rk; phi = a_phi;
            landmark_num = a_lm; busy = a_busy; err = a_err;
        end
    end

    always @(negedge clk) begin
        if (sys_rst_n) begin
            total++;
            if ((a_odo_ready && a_obs_ready) || (b_odo_ready && b_obs_ready)) begin
                bad++;
                $display("FAIL ready_exclusive: got both readies high at %0t, required at most one", $time);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_lm = 0; m_err = 0; m_first = 1;
    endtask

    task automatic send_odo(input logic [31:0] v, input logic [31:0] a);
        bit ok = 0;
        @(negedge clk);
        odo_vlr = v; odo_alpha = a; odo_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (odo_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin @(posedge clk); #1; end
        odo_valid = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL odo_handshake: got ready=0 for 50 cycles, required 1"); end
    endtask

    task automatic send_obs(input logic [31:0] r, input logic [31:0] p, input logic l);
        bit ok = 0;
        @(negedge clk);
        obs_rk = r; obs_phi = p; obs_last = l; obs_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (obs_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin @(posedge clk); #1; end
        obs_valid = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL obs_handshake: got ready=0 for 50 cycles, required 1"); end
    endtask

    // Acts as the EKF core: checks one command and its operands, then pulses stage_rdy
    task automatic expect_cmd(input logic [2:0] code, input logic [31:0] x, input logic [31:0] y, input bit an);
        bit seen = 0;
        bit spur;
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stage_val !== 3'd0) begin seen = 1; break; end
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL cmd_timeout: got no command, required code %0d", code);
            return;
        end
        total++;
        if (stage_val !== code) begin bad++; $display("FAIL cmd_code: got %0d required %0d", stage_val, code); end
        total++;
        if (code == C_PRD) begin
            if (vlr !== x || alpha !== y) begin
                bad++; $display("FAIL prd_operands: got %h/%h required %h/%h", vlr, alpha, x, y);
            end
        end else if (rk !== x || phi !== y) begin
            bad++; $display("FAIL obs_operands: got %h/%h required %h/%h", rk, phi, x, y);
        end
        spur = spur_next;
        if (spur) begin spur_next = 0; stage_rdy = 1'b1; m_err = 1; end
        while (stage_val !== 3'd0 && n < 20) begin
            n++;
            @(negedge clk);
            if (spur && n == 1) stage_rdy = 1'b0;
        end
        total++;
        if (n != 2) begin bad++; $display("FAIL hold_len: got %0d cycles required 2", n); end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        stage_rdy = 1'b1;
        assoc_new = (code == C_ASSOC) ? an : 1'($urandom);
        @(negedge clk);
        stage_rdy = 1'b0;
        assoc_new = 1'($urandom);
    endtask

    task automatic run_obs(input logic [31:0] r, input logic [31:0] p, input logic l);
        bit an;
        send_obs(r, p, l);
        if (m_first != 0) begin
            if (m_lm < cur_max) begin expect_cmd(C_NEW, r, p, 0); m_lm++; end
            else m_err = 1;
        end else begin
            an = (plan_q.size() > 0) ? plan_q.pop_front() : 1'($urandom);
            expect_cmd(C_ASSOC, r, p, an);
            if (!an) expect_cmd(C_UPD, r, p, 0);
            else if (m_lm < cur_max) begin expect_cmd(C_NEW, r, p, 0); m_lm++; end
            else m_err = 1;
        end
        if (l) m_first = 0;
    endtask

    task automatic run_scan(input int n_prd, input int n_obs, input bit fixed);
        logic [31:0] v, a, r, p;
        for (int i = 0; i < n_prd; i++) begin
            v = $urandom; a = $urandom;
            send_odo(v, a);
            expect_cmd(C_PRD, v, a, 0);
        end
        for (int j = 0; j < n_obs; j++) begin
            r = fixed ? 32'd10730636 : $urandom;
            p = fixed ? 32'(-359159) : $urandom;
            run_obs(r, p, j == n_obs - 1);
        end
        repeat (2) @(negedge clk);
        total++;
        if (landmark_num !== 10'(m_lm)) begin
            bad++; $display("FAIL scan_landmarks: got %0d required %0d", landmark_num, m_lm);
        end
        total++;
        if (err !== 1'(m_err)) begin bad++; $display("FAIL scan_err: got %0b required %0d", err, m_err); end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; seq_en_a = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({a_odo_ready, a_obs_ready, a_stage_val, a_vlr, a_alpha, a_rk, a_phi, a_lm, a_busy, a_err} !== '0) begin
            bad++; $display("FAIL reset_main: got nonzero outputs (stage=%0d busy=%0b ready=%0b), required 0",
                            a_stage_val, a_busy, a_odo_ready);
        end
        total++;
        if ({b_odo_ready, b_obs_ready, b_stage_val, b_lm, b_busy, b_err} !== '0) begin
            bad++; $display("FAIL reset_small: got nonzero outputs, required 0");
        end
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_odo();
        logic [31:0] v = 32'(2 << 19);
        logic [31:0] a = 32'(-2221);
        send_odo(v, a);
        total++;
        if (stage_val !== C_PRD) begin bad++; $display("FAIL accept_latency: got %0d required %0d", stage_val, C_PRD); end
        expect_cmd(C_PRD, v, a, 0);
        total++;
        if (busy !== 1'b0 || odo_ready !== 1'b1) begin
            bad++; $display("FAIL prd_done_idle: got busy=%0b ready=%0b required busy=0 ready=1", busy, odo_ready);
        end
    endtask

    task automatic test_first_scan();
        run_scan(cur_prd - 1, 3, 0);
    endtask

    task automatic test_second_scan();
        plan_q.push_back(1'b0);
        plan_q.push_back(1'b1);
        run_scan(cur_prd, 2, 1);
    endtask

    task automatic test_random_scans();
        for (int k = 0; k < 2; k++) run_scan(cur_prd, $urandom_range(1, 4), 0);
    endtask

    task automatic test_spurious();
        spur_next = 1;
        run_scan(cur_prd, 1, 0);
    endtask

    task automatic test_reset_in_assoc();
        bit hit = 0;
        logic [31:0] v, a;
        for (int i = 0; i < cur_prd; i++) begin
            v = $urandom; a = $urandom;
            send_odo(v, a);
            expect_cmd(C_PRD, v, a, 0);
        end
        send_obs($urandom, $urandom, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stage_val === C_ASSOC) hit = 1;
            if (hit && stage_val === 3'd0) break;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL assoc_before_reset: got no ASSOC, required code %0d", C_ASSOC); end
        @(negedge clk);
        #2 sys_rst_n = 1'b0;
        #1;
        total++;
        if ({odo_ready, obs_ready, stage_val, vlr, alpha, rk, phi, landmark_num, busy, err} !== '0) begin
            bad++; $display("FAIL reset_mid_wait: got stage=%0d busy=%0b lm=%0d err=%0b required all 0",
                            stage_val, busy, landmark_num, err);
        end
        @(negedge clk);
        sys_rst_n = 1'b1;
        model_reset();
        v = $urandom; a = $urandom;
        send_odo(v, a);
        expect_cmd(C_PRD, v, a, 0);
        total++;
        if (landmark_num !== 10'd0 || err !== 1'b0) begin
            bad++; $display("FAIL after_reset: got lm=%0d err=%0b required 0/0", landmark_num, err);
        end
    endtask

    task automatic test_max_lm();
        bit quiet = 1;
        @(negedge clk);
        seq_en_a = 1'b0;
        repeat (2) @(negedge clk);
        sel = 1'b1; seq_en_b = 1'b1;
        cur_prd = 2; cur_max = 2;
        model_reset();
        run_scan(cur_prd, 3, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (stage_val !== 3'd0) quiet = 0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL max_lm_no_new: got a command after saturation, required none"); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL max_lm_idle: got busy=%0b required 0", busy); end
    endtask

    initial begin
        cur_prd = 10; cur_max = 1023;
        model_reset();
        test_reset();
        test_single_odo();
        test_first_scan();
        test_second_scan();
        test_random_scans();
        test_spurious();
        test_reset_in_assoc();
        test_max_lm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ekf_stage_sequencer.md
Name: ekf_stage_sequencer

Overview:
- Upstream command sequencer for the EKF-SLAM core (Top).
- Consumes odometry samples (vlr, alpha) and observation scans (rk, phi) over valid/ready streams.
- Drives Top's stage_val/vlr/alpha/rk/phi operands and paces itself on Top's stage_rdy.
- Decides the order PRD → NEW (first scan) or ASSOC → NEW/UPD (later scans), and tracks landmark count.

Parameters:
- RSA_DW, 32, operand width (Q1.12.19 signed).
- ROW_LEN, 10, landmark counter width.
- PRD_PER_SCAN, 10, predictions issued between consecutive observation scans.
- STAGE_HOLD, 2, cycles stage_val is held non-zero per command.
- MAX_LM, 1023, landmark count saturation value.

Ports:
- clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- seq_en  in  1  sequencer enable; sampled only in IDLE.
- odo_valid  in  1  odometry sample valid.
- odo_ready  out  1  odometry accepted when odo_valid && odo_ready.
- odo_vlr  in  RSA_DW  wheel velocity.
- odo_alpha  in  RSA_DW  steering angle.
- obs_valid  in  1  observation valid.
- obs_ready  out  1  observation handshake ready.
- obs_rk  in  RSA_DW  range.
- obs_phi  in  RSA_DW  bearing.
- obs_last  in  1  marks last observation of a scan.
- stage_val  out  3  command to Top: 000 idle, 001 PRD, 010 NEW, 011 UPD, 100 ASSOC.
- vlr, alpha, rk, phi  out  RSA_DW each  registered operands to Top.
- stage_rdy  in  1  one-cycle completion pulse from Top.
- assoc_new  in  1  ASSOC result, valid in the stage_rdy cycle; 1 = unmatched landmark.
- landmark_num  out  ROW_LEN  landmarks initialised so far.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async, sys_rst_n=0): all outputs 0; state IDLE; prd_cnt=0; first_scan=1. A reset mid-command abandons the command without any handshake.

State IDLE:
- If seq_en=0, stay in IDLE.
- If prd_cnt < PRD_PER_SCAN: odo_ready=1. On handshake, latch vlr/alpha, cmd=PRD, go to ISSUE.
- Otherwise go to OBS_FETCH.

State OBS_FETCH:
- obs_ready=1. On handshake, latch rk/phi/obs_last.
- cmd = first_scan ? NEW : ASSOC; go to ISSUE.

State ISSUE:
- stage_val=cmd for exactly STAGE_HOLD cycles (hold_cnt), then 000; go to WAIT.
- Operands stay stable from latch until the next latch.

State WAIT:
- stage_val=000; wait for stage_rdy.
- PRD done: prd_cnt++; go to IDLE.
- NEW done: landmark_num++; go to NEXT.
- UPD done: go to NEXT.
- ASSOC done with assoc_new=1: cmd=NEW; go to ISSUE, same rk/phi.
- ASSOC done with assoc_new=0: cmd=UPD; go to ISSUE.

State NEXT (1 cycle):
- If latched last=1: prd_cnt=0, first_scan=0; go to IDLE.
- Otherwise go to OBS_FETCH.

Handshake latencies:
- Accept to stage_val asserted: 1 cycle.
- stage_rdy to next stage_val: ≥2 cycles.

Boundary conditions:
- stage_rdy while in IDLE/ISSUE/OBS_FETCH: ignored; err=1.
- NEW requested with landmark_num==MAX_LM: NEW not issued; err=1; go to NEXT; count unchanged.
- odo_ready and obs_ready are never high together. Valid inputs are held off while ready=0; no data is dropped.
- seq_en deasserted mid-sequence: the current command and scan complete; the block stops only on return to IDLE.
- assoc_new is ignored except in the cycle stage_rdy completes an ASSOC.

Decomposition:
- Shared package: stage code constants (STAGE_IDLE/PRD/NEW/UPD/ASSOC), data format constants (DATA_INT_BIT=12, DATA_DEC_BIT=19), state encoding type.
- No sub-module needed. The hold counter, prd_cnt and landmark counter sit inline in a single FSM module.

Test Plan:
- Reset, seq_en=1, one odo (vlr=2<<19, alpha=-2221) → one cycle later stage_val=001 for 2 cycles with vlr/alpha matching; stage_rdy pulse → busy=0, odo_ready=1.
- 10 odo samples, then first scan of 3 obs (last on 3rd) → 10 PRD then 3 NEW; landmark_num=3; first_scan cleared.
- Second scan, 2 obs (rk=10730636, phi=-359159), assoc_new=0 then 1 → ASSOC,UPD,ASSOC,NEW; landmark_num 3→4.
- Spurious stage_rdy during ISSUE → err=1, sequence continues unchanged.
- MAX_LM=2 build, first scan of 3 obs → landmark_num=2, err=1, third NEW not issued, returns to IDLE.
- Assert reset during WAIT of an ASSOC → all outputs 0; after release, next odo is issued as PRD with prd_cnt=0.
